nios2_pio_ctrl: RTL
===================

# nios2_pio_ctrl

Parametrised general-purpose I/O port on the NIOS2 Avalon-MM peripheral bus, generalising the single-bit write-only strobe ports (e.g. the RAM write-enable port) to WIDTH bits with per-bit direction, atomic set/clear, synchronised inputs, edge capture and a maskable interrupt. It sits between the system interconnect and board pins/FPGA logic (DSO trigger flags, control strobes, status lines), one instance per port group.

## Interface
- WIDTH, 8: port width, 1..32.
- RESET_VALUE, 0: out_port value after reset (WIDTH bits).
- DIR_RESET, 0: direction after reset; bit = 1 means output.
- EDGE_TYPE, 0: capture on 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

- clk  in  1  system clock; the block's only clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data, combinational from address; bits above WIDTH are 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  direction register; drives pad tristate enables.
- irq  out  1  level interrupt, registered.

## Operation
- Write strobe: chipselect && !write_n. One access per cycle.
- Register map:
  - 0 DATA: write loads data_out. Read returns sync_in for dir = 0 bits, data_out for dir = 1 bits.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write; reset 0.
  - 3 EDGE: read edge_capture; write-1-to-clear.
  - 4 OUTSET: write data_out |= wd; reads 0.
  - 5 OUTCLR: write data_out &= ~wd; reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Writes to DATA for input-direction bits still update data_out. The value is driven when the bit later becomes an output.
- Input path: SYNC_STAGES flop chain gives sync_in, then one prev register. The edge term per bit is chosen by EDGE_TYPE from sync_in and prev.
- Capture only on dir = 0 bits. Captured bits stay set until cleared by software.
- Simultaneous EDGE clear and new edge on the same bit: set wins, no edge is lost.
- Arming counter: after reset, edge detection is suppressed until SYNC_STAGES+1 clocks have elapsed. This prevents spurious capture from high pins. The counter then saturates with armed = 1.
- irq_next = |(edge_capture & irq_mask). irq is registered from irq_next.

## Timing
- Reset values:
  - out_port = RESET_VALUE, oe = DIR_RESET.
  - mask = 0, edge_capture = 0, irq = 0.
  - Sync chain and prev = 0, armed = 0.
- Register writes are visible on outputs and readdata at the next rising edge.
- Reads: zero wait states; readdata is combinational.
- in_port change to sync_in: SYNC_STAGES edges.
- Edge to edge_capture bit set: 1 further edge.
- Capture set to irq high: 1 edge, with the bit unmasked.
- Clear write at edge N: irq low after edge N+1, unless another masked bit is still set.
- Mask write takes effect on irq with the same 1-cycle lag.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and re-arming restarts.

## Structure
- Package nios2_pio_pkg:
  - register address constants: ADDR_DATA, ADDR_DIR, ADDR_MASK, ADDR_EDGE, ADDR_SET, ADDR_CLR;
  - EDGE_TYPE encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module nios2_pio_sync:
  - WIDTH-wide synchroniser plus prev register;
  - outputs sync_in and an edge vector per EDGE_TYPE;
  - contains the arming counter.
- Top level holds the bus decode, data_out / dir / mask / edge_capture registers and the irq flop.

## Test plan
- Reset with in_port = 0xFF, WIDTH = 8, DIR_RESET = 0 -> EDGE reads 0x00, irq = 0 after 10 cycles, out_port = RESET_VALUE.
- Write DIR = 0xF0, DATA = 0xA5, OUTSET = 0x0A, OUTCLR = 0x20 -> out_port = 0x8F. DATA read with in_port = 0x03 returns 0x83.
- Rising edge on in_port[2], mask = 0x04 -> EDGE = 0x04 at SYNC_STAGES+1 edges; irq high 1 edge later.
- Write EDGE = 0x04 in the same cycle a new edge on bit 2 is captured -> EDGE stays 0x04, irq stays high.
- EDGE_TYPE = 2, pulse bit 0 high for 5 cycles, mask = 0 -> EDGE = 0x01, irq = 0. Set mask = 0x01 -> irq = 1 after 1 edge.
- Assert reset_n low mid-pulse with irq = 1 -> irq, edge_capture and out_port return to reset values within the same cycle; no capture for SYNC_STAGES+1 cycles after release.

Source files
------------

// File: rtl/nios2_pio_pkg.sv
// Shared constants and bus payload type for the NIOS2 Avalon-MM parallel I/O port.
package nios2_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CLR  = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  data;
    } pio_bus_req_t;

endpackage

// File: rtl/nios2_pio_sync.sv
// Pin input synchroniser with previous-value register, edge detect and
// post-reset arming so pins already high at reset do not look like edges.
module nios2_pio_sync
    import nios2_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_c
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] arm_cnt;
    logic             armed;
    logic [WIDTH-1:0] edge_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Arms once the chain has flushed its reset zeros, then holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt == CNT_W'(SYNC_STAGES)) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + CNT_W'(1);
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_raw = ~sync_in & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_raw = sync_in ^ prev_q;
        end else begin : g_rise
            assign edge_raw = sync_in & ~prev_q;
        end
    endgenerate

    assign edge_c = armed ? edge_raw : '0;

endmodule

// File: rtl/nios2_pio_ctrl.sv
// Avalon-MM general-purpose I/O port: per-bit direction, atomic set/clear,
// synchronised inputs with edge capture and a maskable level interrupt.
module nios2_pio_ctrl
    import nios2_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    pio_bus_req_t     req;
    logic [WIDTH-1:0] wd;
    logic             unused_bits;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_capture;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_c;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_next;
    logic             irq_next;
    logic [WIDTH-1:0] rd_word;

    assign req         = '{wr: chipselect && !write_n, addr: address, data: writedata};
    assign wd          = req.data[WIDTH-1:0];
    assign unused_bits = ^req.data;

    nios2_pio_sync #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_in (sync_in),
        .edge_c  (edge_c)
    );

    // A new edge beats a same-cycle software clear so no event is lost.
    always_comb begin
        edge_clr  = '0;
        if (req.wr && req.addr == ADDR_EDGE) begin
            edge_clr = wd;
        end
        edge_next = (edge_capture & ~edge_clr) | (edge_c & ~dir);
        irq_next  = |(edge_capture & mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= RESET_VALUE;
            dir          <= DIR_RESET;
            mask         <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            if (req.wr) begin
                case (req.addr)
                    ADDR_DATA: data_out <= wd;
                    ADDR_SET:  data_out <= data_out | wd;
                    ADDR_CLR:  data_out <= data_out & ~wd;
                    ADDR_DIR:  dir      <= wd;
                    ADDR_MASK: mask     <= wd;
                    default: ;
                endcase
            end
            edge_capture <= edge_next;
            irq          <= irq_next;
        end
    end

    // DATA reads pins on inputs and the driven value on outputs.
    always_comb begin
        rd_word = '0;
        case (req.addr)
            ADDR_DATA: rd_word = (sync_in & ~dir) | (data_out & dir);
            ADDR_DIR:  rd_word = dir;
            ADDR_MASK: rd_word = mask;
            ADDR_EDGE: rd_word = edge_capture;
            default:   rd_word = '0;
        endcase
    end

    assign readdata = 32'(rd_word);
    assign out_port = data_out;
    assign oe       = dir;

endmodule
